fpga_wb_master_arbiter: RTL
===========================

Name: fpga_wb_master_arbiter

Overview:
Two-master Wishbone arbiter that shares the single FPGA-IP Wishbone slave bus (17-bit byte address, 32-bit data) between the AHB-to-FPGA bridge (master 0) and an internal FPGA-side master such as an LPC-to-WB or DMA engine (master 1). It sits between the masters and the address decoder / read-data mux. It grants round-robin on contention and holds the grant for the full CYC. A bus watchdog terminates stalled transfers with a default read value so neither master can hang.

Parameters:
ADDRWIDTH, 17, Wishbone byte-address width.
DATAWIDTH, 32, Wishbone data width.
TIMEOUT_CYCLES, 64, cycles STB may remain un-ACKed before forced termination; must be >= 1.
DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, read data returned on a timed-out transfer.
ERRCNT_WIDTH, 8, width of the saturating timeout counter.

Ports:
WB_CLK  input  1  Wishbone clock; the only clock.
WB_RST  input  1  asynchronous, active-high reset.
WBm0_ADR / WBm1_ADR  input  ADDRWIDTH  master 0/1 address.
WBm0_CYC / WBm1_CYC  input  1  master 0/1 cycle (bus request).
WBm0_BYTE_STB / WBm1_BYTE_STB  input  4  byte enables.
WBm0_WE / WBm1_WE  input  1  write enable.
WBm0_STB / WBm1_STB  input  1  transfer strobe.
WBm0_WR_DAT / WBm1_WR_DAT  input  DATAWIDTH  write data.
WBm0_RD_DAT / WBm1_RD_DAT  output  DATAWIDTH  read data to master.
WBm0_ACK / WBm1_ACK  output  1  acknowledge to master.
WBs_ADR, WBs_CYC, WBs_BYTE_STB, WBs_WE, WBs_STB, WBs_WR_DAT  output  (ADDRWIDTH,1,4,1,1,DATAWIDTH)  forwarded slave-side bus.
WBs_RD_DAT  input  DATAWIDTH  slave read data.
WBs_ACK  input  1  slave acknowledge.
GRANT_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 0 when idle.
TIMEOUT_o  output  1  one-cycle pulse on forced termination.
ERR_CNT_o  output  ERRCNT_WIDTH  saturating count of timeouts.

Behaviour:
- Reset (async, WB_RST = 1): state IDLE, owner = none, last_served = m1 (so m0 wins the first tie), watchdog = 0, ERR_CNT_o = 0. All outputs 0, including WBs_CYC/STB, both ACKs, both RD_DATs, GRANT_o and TIMEOUT_o. Assertion mid-transfer aborts the transfer immediately; no ACK is issued.
- States: IDLE, OWN0, OWN1, TOUT.
- IDLE:
  - Slave outputs are all 0; WBs_ACK is ignored.
  - Only m0 CYC high -> OWN0. Only m1 CYC high -> OWN1.
  - Both high -> grant the master that is not last_served.
  - Arbitration latency is 1 cycle: the registered grant is visible at the next edge.
- OWNx:
  - Owner's ADR/CYC/BYTE_STB/WE/STB/WR_DAT are combinationally routed to WBs_*.
  - Owner ACK = WBs_ACK; owner RD_DAT = WBs_RD_DAT.
  - Non-owner ACK = 0 and RD_DAT = 0; its request waits.
  - Grant is held while owner CYC = 1, so back-to-back STBs and read-modify-write are atomic.
  - Owner CYC = 0 -> IDLE and last_served = x. A 1-cycle idle gap always precedes re-arbitration.
- Watchdog:
  - Counts cycles in OWNx with owner STB = 1 and WBs_ACK = 0.
  - Clears on WBs_ACK, on STB = 0, and on entering or leaving OWNx.
  - Width is clog2(TIMEOUT_CYCLES+1).
  - When the count reaches TIMEOUT_CYCLES with WBs_ACK still 0 -> TOUT.
  - If WBs_ACK arrives on the threshold cycle, ACK wins and there is no timeout.
- TOUT (exactly 1 cycle):
  - WBs_CYC = WBs_STB = 0.
  - Owner ACK = 1; owner RD_DAT = DEFAULT_READ_VALUE (also returned for writes).
  - TIMEOUT_o = 1.
  - ERR_CNT_o increments, saturating at all-ones.
  - Next state: OWNx if owner CYC is still 1, else IDLE with last_served = x.
  - Any late WBs_ACK that arrives in TOUT or IDLE is dropped.
- GRANT_o reflects the owner in OWNx and TOUT.
- Outputs in OWNx are combinational from owner inputs; all state is registered on WB_CLK.

Test Plan:
- Single master: m0 reads ADR 0x03004; slave ACKs 2 cycles after STB with 0x1234_5678 -> WBm0_ACK one cycle, WBm0_RD_DAT = 0x1234_5678, GRANT_o = 01, WBm1_ACK never asserted.
- Contention from reset: m0 and m1 raise CYC on the same cycle; each does 1 write then drops CYC; both re-request -> service order m0, m1, m0, m1. There is a 1-cycle IDLE gap (GRANT_o = 00) between owners.
- Grant hold: m1 owns and issues 3 back-to-back STBs while m0 requests -> all 3 m1 transfers complete before m0 sees its first ACK; WBs_ADR never shows m0's address during the m1 CYC.
- Timeout: TIMEOUT_CYCLES = 4; m0 reads an unmapped address and the slave never ACKs -> TIMEOUT_o high on the 5th cycle after STB, WBm0_RD_DAT = 0xBADFABAC with ACK, ERR_CNT_o = 1; 300 repeated timeouts -> ERR_CNT_o = 0xFF.
- Boundary ACK: slave ACK lands exactly on the threshold cycle -> normal ACK with slave data, TIMEOUT_o = 0, ERR_CNT_o unchanged.
- Async reset mid-transfer: assert WB_RST while m1 STB is waiting -> all outputs 0 with no clock edge, no ACK issued; after release, m0 wins the first tie.

Source files
------------

// File: rtl/fpga_wb_master_arbiter.sv
// Two-master Wishbone arbiter. The grant is round-robin and held for the whole CYC.
// A watchdog force-terminates strobes the slave never acknowledges.
module fpga_wb_master_arbiter #(
  parameter int                   ADDRWIDTH          = 17,
  parameter int                   DATAWIDTH          = 32,
  parameter int                   TIMEOUT_CYCLES     = 64,
  parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC,
  parameter int                   ERRCNT_WIDTH       = 8
) (
  input  logic                    WB_CLK,
  input  logic                    WB_RST,

  input  logic [ADDRWIDTH-1:0]    WBm0_ADR,
  input  logic                    WBm0_CYC,
  input  logic [3:0]              WBm0_BYTE_STB,
  input  logic                    WBm0_WE,
  input  logic                    WBm0_STB,
  input  logic [DATAWIDTH-1:0]    WBm0_WR_DAT,
  output logic [DATAWIDTH-1:0]    WBm0_RD_DAT,
  output logic                    WBm0_ACK,

  input  logic [ADDRWIDTH-1:0]    WBm1_ADR,
  input  logic                    WBm1_CYC,
  input  logic [3:0]              WBm1_BYTE_STB,
  input  logic                    WBm1_WE,
  input  logic                    WBm1_STB,
  input  logic [DATAWIDTH-1:0]    WBm1_WR_DAT,
  output logic [DATAWIDTH-1:0]    WBm1_RD_DAT,
  output logic                    WBm1_ACK,

  output logic [ADDRWIDTH-1:0]    WBs_ADR,
  output logic                    WBs_CYC,
  output logic [3:0]              WBs_BYTE_STB,
  output logic                    WBs_WE,
  output logic                    WBs_STB,
  output logic [DATAWIDTH-1:0]    WBs_WR_DAT,
  input  logic [DATAWIDTH-1:0]    WBs_RD_DAT,
  input  logic                    WBs_ACK,

  output logic [1:0]              GRANT_o,
  output logic                    TIMEOUT_o,
  output logic [ERRCNT_WIDTH-1:0] ERR_CNT_o
);

  localparam int                WDOG_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1, ST_TOUT} state_t;

  state_t                  state_reg;
  logic                    owner_reg;
  logic                    last_served_reg;
  logic [WDOG_W-1:0]       wdog_reg;
  logic [ERRCNT_WIDTH-1:0] err_cnt_reg;
  logic [1:0]              grant_reg;
  logic                    timeout_reg;

  logic [ADDRWIDTH-1:0]    m_adr  [2];
  logic [3:0]              m_sel  [2];
  logic [DATAWIDTH-1:0]    m_wdat [2];
  logic [DATAWIDTH-1:0]    m_rdat [2];
  logic [1:0]              m_cyc;
  logic [1:0]              m_stb;
  logic [1:0]              m_we;
  logic [1:0]              m_ack;

  logic own_active;
  logic in_tout;
  logic own_cyc;
  logic own_stb;

  assign m_adr[0]  = WBm0_ADR;
  assign m_adr[1]  = WBm1_ADR;
  assign m_sel[0]  = WBm0_BYTE_STB;
  assign m_sel[1]  = WBm1_BYTE_STB;
  assign m_wdat[0] = WBm0_WR_DAT;
  assign m_wdat[1] = WBm1_WR_DAT;
  assign m_cyc     = {WBm1_CYC, WBm0_CYC};
  assign m_stb     = {WBm1_STB, WBm0_STB};
  assign m_we      = {WBm1_WE, WBm0_WE};

  assign own_active = (state_reg == ST_OWN0) || (state_reg == ST_OWN1);
  assign in_tout    = (state_reg == ST_TOUT);
  assign own_cyc    = m_cyc[owner_reg];
  assign own_stb    = m_stb[owner_reg];

  // Slave bus is driven only while a master owns it; TOUT and IDLE park it at zero.
  assign WBs_ADR      = own_active ? m_adr[owner_reg]  : '0;
  assign WBs_CYC      = own_active & own_cyc;
  assign WBs_BYTE_STB = own_active ? m_sel[owner_reg]  : '0;
  assign WBs_WE       = own_active & m_we[owner_reg];
  assign WBs_STB      = own_active & own_stb;
  assign WBs_WR_DAT   = own_active ? m_wdat[owner_reg] : '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    localparam logic ME = 1'(gi);
    logic selected;
    assign selected = (owner_reg == ME);
    assign m_ack[gi]  = selected & ((own_active & WBs_ACK) | in_tout);
    assign m_rdat[gi] = !selected ? '0 :
                        own_active ? WBs_RD_DAT :
                        in_tout ? DEFAULT_READ_VALUE : '0;
  end

  assign WBm0_ACK    = m_ack[0];
  assign WBm1_ACK    = m_ack[1];
  assign WBm0_RD_DAT = m_rdat[0];
  assign WBm1_RD_DAT = m_rdat[1];

  assign GRANT_o   = grant_reg;
  assign TIMEOUT_o = timeout_reg;
  assign ERR_CNT_o = err_cnt_reg;

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      state_reg       <= ST_IDLE;
      owner_reg       <= 1'b0;
      last_served_reg <= 1'b1;
      wdog_reg        <= '0;
      err_cnt_reg     <= '0;
      grant_reg       <= 2'b00;
      timeout_reg     <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          wdog_reg <= '0;
          // On a tie the master that was not served last wins.
          if (m_cyc[0] && (!m_cyc[1] || last_served_reg)) begin
            state_reg <= ST_OWN0;
            owner_reg <= 1'b0;
            grant_reg <= 2'b01;
          end else if (m_cyc[1]) begin
            state_reg <= ST_OWN1;
            owner_reg <= 1'b1;
            grant_reg <= 2'b10;
          end
        end

        ST_OWN0, ST_OWN1: begin
          if (!own_cyc) begin
            state_reg       <= ST_IDLE;
            last_served_reg <= owner_reg;
            grant_reg       <= 2'b00;
            wdog_reg        <= '0;
          end else if (WBs_ACK || !own_stb) begin
            wdog_reg <= '0;
          end else if (wdog_reg == WDOG_LIMIT) begin
            // An ACK on this same cycle would have taken the branch above.
            state_reg   <= ST_TOUT;
            timeout_reg <= 1'b1;
            wdog_reg    <= '0;
            if (err_cnt_reg != '1) begin
              err_cnt_reg <= err_cnt_reg + ERRCNT_WIDTH'(1);
            end
          end else begin
            wdog_reg <= wdog_reg + WDOG_W'(1);
          end
        end

        ST_TOUT: begin
          wdog_reg <= '0;
          if (own_cyc) begin
            state_reg <= owner_reg ? ST_OWN1 : ST_OWN0;
          end else begin
            state_reg       <= ST_IDLE;
            last_served_reg <= owner_reg;
            grant_reg       <= 2'b00;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= 2'b00;
          wdog_reg  <= '0;
        end
      endcase
    end
  end

endmodule
